// File: rtl/cache_line_fill_if.sv
// Bus bundle for the line-fill stage: miss request, byte-wide memory
// read port, and the write port into the cache data/tag arrays.
//
// Handshake: a miss request transfers on a rising edge where req_valid
// and req_ready are both 1. req_ready is 1 only while the fill engine is
// idle. The requester holds req_valid and req_addr stable until the
// transfer. The memory side is not stalled: mem_rd_en is a one-cycle
// strobe, and each strobe is answered by exactly one cycle of
// mem_rd_valid after one or more cycles.
interface cache_line_fill_if #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 18
);
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd_valid;
  logic [7:0]         mem_rd_data;
  logic               fill_we;
  logic [INDEX_W-1:0] fill_index;
  logic [3:0]         fill_word;
  logic [31:0]        fill_data;
  logic               fill_tag_we;
  logic [TAG_W-1:0]   fill_tag;
  logic               fill_done;
  logic [31:0]        done_data;
  logic [31:0]        fill_count;

  // View taken by the fill engine itself.
  modport slave (
    input  req_valid, req_addr, mem_rd_valid, mem_rd_data,
    output req_ready, mem_rd_en, mem_addr, fill_we, fill_index, fill_word,
           fill_data, fill_tag_we, fill_tag, fill_done, done_data, fill_count
  );

  // View taken by whatever drives requests and models memory.
  modport master (
    output req_valid, req_addr, mem_rd_valid, mem_rd_data,
    input  req_ready, mem_rd_en, mem_addr, fill_we, fill_index, fill_word,
           fill_data, fill_tag_we, fill_tag, fill_done, done_data, fill_count
  );
endinterface

// File: rtl/cache_line_fill.sv
// Cache line fill engine. Reads a 64-byte line one byte at a time from
// main memory, packs bytes big-endian into 32-bit words, writes the 16
// words into the data array in order, then writes the tag and returns
// the word that originally missed. Counts completed fills.
module cache_line_fill #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 18,
  parameter int WORDS   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_line_fill_if.slave  bus,
  output logic [2:0]        dbg_state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [3:0]         offset_q, offset_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [5:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        asm_q, asm_d;
  logic [31:0]        crit_q, crit_d;
  logic [31:0]        count_q, count_d;

  // The counter has already advanced past the last byte of the word when
  // WRITE is reached, so the completed slot is one behind; after the
  // 64th byte the 6-bit counter wraps to 0 and this yields 15.
  logic [3:0] word_now;
  assign word_now = byte_cnt_q[5:2] - 4'd1;

  // Next-state and datapath updates for the fill sequence.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    offset_d   = offset_q;
    index_d    = index_q;
    tag_d      = tag_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    crit_d     = crit_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          base_d     = bus.req_addr & ~ADDR_W'(6'h3F);
          offset_d   = bus.req_addr[5:2];
          index_d    = bus.req_addr[6 +: INDEX_W];
          tag_d      = bus.req_addr[ADDR_W-1 -: TAG_W];
          byte_cnt_d = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_rd_valid) begin
          asm_d      = {asm_q[23:0], bus.mem_rd_data};
          byte_cnt_d = byte_cnt_q + 6'd1;
          state_d    = (byte_cnt_q[1:0] == 2'd3) ? S_WRITE : S_ISSUE;
        end
      end
      S_WRITE: begin
        if (word_now == offset_q) crit_d = asm_q;
        state_d = (word_now == LAST_WORD) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        count_d = count_q + 32'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      offset_q   <= '0;
      index_q    <= '0;
      tag_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      crit_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      offset_q   <= offset_d;
      index_q    <= index_d;
      tag_q      <= tag_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      crit_q     <= crit_d;
      count_q    <= count_d;
    end
  end

  // Outputs decode directly from state; data outputs read 0 outside
  // their strobe cycles, while index/tag/address simply hold.
  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.mem_rd_en   = (state_q == S_ISSUE);
  assign bus.mem_addr    = base_q + ADDR_W'(byte_cnt_q);
  assign bus.fill_we     = (state_q == S_WRITE);
  assign bus.fill_index  = index_q;
  assign bus.fill_word   = (state_q == S_WRITE) ? word_now : 4'd0;
  assign bus.fill_data   = (state_q == S_WRITE) ? asm_q : 32'd0;
  assign bus.fill_tag_we = (state_q == S_DONE);
  assign bus.fill_tag    = tag_q;
  assign bus.fill_done   = (state_q == S_DONE);
  assign bus.done_data   = (state_q == S_DONE) ? crit_q : 32'd0;
  assign bus.fill_count  = count_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: memory model returns byte A[7:0] at address
// A, a scoreboard predicts every memory address, data-array write and
// completion, and directed steps cover latency, busy, wrap and reset.
module tb_cache_line_fill;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  cache_line_fill_if bus ();

  cache_line_fill dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard state
  logic [43:0] exp_q[$];   // {index, word, data}
  logic [49:0] done_q[$];  // {tag, critical word}
  logic [31:0] addr_q[$];  // expected memory byte addresses
  int          we_cnt, rd_cnt, tag_cnt, done_cnt, acc_cnt;
  int          acc_cyc, done_cyc;
  logic [31:0] exp_count;
  bit          cnt_chk;
  logic [31:0] last_done_data, last_rd_addr, first_rd_addr, word0_data;
  logic [31:0] last_we_data;
  logic [7:0]  last_index;
  logic [17:0] last_tag;
  logic [3:0]  last_we_word;
  bit          rand_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] line_word(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {a[7:0], a1[7:0], a2[7:0], a3[7:0]};
  endfunction

  task automatic flush();
    exp_q.delete();
    done_q.delete();
    addr_q.delete();
    we_cnt    = 0;
    rd_cnt    = 0;
    tag_cnt   = 0;
    exp_count = 0;
    cnt_chk   = 0;
  endtask

  // memory responder: one read outstanding, fixed or random latency
  initial begin : mem_model
    bit          pending;
    int          rcnt;
    logic [31:0] pend_addr;
    logic        nv;
    logic [7:0]  nd;
    pending = 0;
    rcnt = 0;
    pend_addr = '0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = 8'd0;
    forever begin
      @(negedge clk);
      nv = 1'b0;
      nd = 8'($urandom_range(0, 255));
      if (!rst_n) begin
        pending = 0;
      end else begin
        if (bus.mem_rd_en) begin
          chk("one_outstanding", 64'(pending), 64'd0);
          pending   = 1;
          pend_addr = bus.mem_addr;
          rcnt      = rand_mode ? int'($urandom_range(1, 5)) : 1;
        end
        if (pending) begin
          if (rcnt == 1) begin
            nv = 1'b1;
            nd = pend_addr[7:0];
            pending = 0;
          end else begin
            rcnt--;
          end
        end else if (rand_mode) begin
          nv = 1'($urandom_range(0, 1));
        end
      end
      @(posedge clk);
      #1;
      bus.mem_rd_valid = nv;
      bus.mem_rd_data  = nd;
    end
  end

  // monitor / scoreboard: samples at the falling edge
  initial begin : monitor
    logic [31:0] base;
    logic [49:0] de;
    logic [43:0] we;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cnt_chk) begin
          cnt_chk = 0;
          chk("fill_count", 64'(bus.fill_count), 64'(exp_count));
        end
        if (bus.mem_rd_en) begin
          if (addr_q.size() == 0) chk("unexpected_rd", 64'd1, 64'd0);
          else chk("mem_addr", 64'(bus.mem_addr), 64'(addr_q.pop_front()));
          if (rd_cnt == 0) first_rd_addr = bus.mem_addr;
          last_rd_addr = bus.mem_addr;
          rd_cnt++;
        end
        if (bus.fill_we) begin
          if (exp_q.size() == 0) chk("unexpected_we", 64'd1, 64'd0);
          else begin
            we = exp_q.pop_front();
            chk("fill_write", 64'({bus.fill_index, bus.fill_word, bus.fill_data}), 64'(we));
          end
          if (bus.fill_word == 4'd0) word0_data = bus.fill_data;
          last_we_word = bus.fill_word;
          last_we_data = bus.fill_data;
          we_cnt++;
        end
        if (bus.fill_tag_we) tag_cnt++;
        if (bus.fill_done) begin
          if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else begin
            de = done_q.pop_front();
            chk("done_tag_data", 64'({bus.fill_tag, bus.done_data}), 64'(de));
          end
          chk("we_before_done", 64'(we_cnt), 64'd16);
          chk("tag_we_with_done", 64'(tag_cnt), 64'd1);
          chk("rd_en_per_fill", 64'(rd_cnt), 64'd64);
          last_done_data = bus.done_data;
          last_index     = bus.fill_index;
          last_tag       = bus.fill_tag;
          we_cnt  = 0;
          rd_cnt  = 0;
          tag_cnt = 0;
          exp_count = exp_count + 32'd1;
          cnt_chk = 1;
          done_cnt++;
          done_cyc = cyc;
        end else if (bus.fill_tag_we) begin
          chk("tag_we_without_done", 64'd1, 64'd0);
        end
        if (bus.req_valid && bus.req_ready) begin
          base = bus.req_addr & 32'hFFFF_FFC0;
          for (int k = 0; k < 16; k++)
            exp_q.push_back({bus.req_addr[13:6], 4'(k), line_word(base + 32'(4 * k))});
          for (int j = 0; j < 64; j++) addr_q.push_back(base + 32'(j));
          done_q.push_back({bus.req_addr[31:14],
                            line_word(base + {26'd0, bus.req_addr[5:2], 2'b00})});
          acc_cnt++;
          acc_cyc = cyc;
        end
      end
    end
  end

  // driver tasks
  task automatic do_req(input logic [31:0] addr, input bit hold);
    int start;
    bit ok;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    start = acc_cnt;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != start) ok = 1;
    end
    if (!ok) chk("accept_timeout", 64'd1, 64'd0);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int start;
    bit ok;
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != start) ok = 1;
    end
    if (!ok) chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // directed sequence
  initial begin : stim
    int start, d0;
    bit ok;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'd0;
    rand_mode = 0;
    acc_cnt = 0;
    done_cnt = 0;
    flush();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_fill_we", 64'(bus.fill_we), 64'd0);
    chk("rst_fill_tag_we", 64'(bus.fill_tag_we), 64'd0);
    chk("rst_fill_done", 64'(bus.fill_done), 64'd0);
    chk("rst_fill_count", 64'(bus.fill_count), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    // latency 1, directed request
    do_req(32'h0000_1234, 0);
    wait_done(300);
    chk("t1_cycles", 64'(done_cyc - acc_cyc), 64'd145);
    chk("t1_done_data", 64'(last_done_data), 64'h3435_3637);
    chk("t1_index", 64'(last_index), 64'h48);
    chk("t1_tag", 64'(last_tag), 64'h0);
    chk("t1_word0", 64'(word0_data), 64'h0001_0203);
    chk("t1_count", 64'(bus.fill_count), 64'd1);

    // random latency plus spurious valid outside WAIT
    rand_mode = 1;
    do_req(32'h0000_1234, 0);
    wait_done(1000);
    rand_mode = 0;
    chk("t2_done_data", 64'(last_done_data), 64'h3435_3637);
    chk("t2_word0", 64'(word0_data), 64'h0001_0203);
    chk("t2_count", 64'(bus.fill_count), 64'd2);

    // second request held while busy
    apply_reset();
    do_req(32'h0000_1234, 1);
    bus.req_addr = 32'h0000_5678;
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != start) ok = 1;
      else chk("busy_ready_low", 64'(bus.req_ready), 64'd0);
    end
    if (!ok) chk("t3_done_timeout", 64'd1, 64'd0);
    d0 = done_cyc;
    start = acc_cnt;
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != start) ok = 1;
    end
    bus.req_valid = 1'b0;
    chk("t3_accept_after_done", 64'(acc_cyc - d0), 64'd1);
    wait_done(300);
    chk("t3_done_data", 64'(last_done_data), 64'h7879_7A7B);
    chk("t3_index", 64'(last_index), 64'h59);
    chk("t3_count", 64'(bus.fill_count), 64'd2);

    // top-of-memory line
    do_req(32'hFFFF_FFFC, 0);
    wait_done(300);
    chk("t4_first_addr", 64'(first_rd_addr), 64'hFFFF_FFC0);
    chk("t4_last_addr", 64'(last_rd_addr), 64'hFFFF_FFFF);
    chk("t4_index", 64'(last_index), 64'hFF);
    chk("t4_tag", 64'(last_tag), 64'h3FFFF);
    chk("t4_last_word", 64'(last_we_word), 64'd15);
    chk("t4_last_data", 64'(last_we_data), 64'hFCFD_FEFF);
    chk("t4_done_data", 64'(last_done_data), 64'hFCFD_FEFF);
    chk("t4_count", 64'(bus.fill_count), 64'd3);

    // reset in the middle of a fill
    do_req(32'h0000_1234, 0);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (we_cnt >= 5) ok = 1;
    end
    if (!ok) chk("t5_we_timeout", 64'd1, 64'd0);
    start = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    flush();
    chk("t5_req_ready", 64'(bus.req_ready), 64'd1);
    chk("t5_fill_count", 64'(bus.fill_count), 64'd0);
    chk("t5_strobes", 64'({bus.mem_rd_en, bus.fill_we, bus.fill_tag_we, bus.fill_done}), 64'd0);
    chk("t5_data", 64'({bus.fill_data, bus.done_data}), 64'd0);
    chk("t5_state", 64'(dbg_state), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_done_after_abort", 64'(done_cnt - start), 64'd0);
    chk("t5_no_tag_we_after_abort", 64'(tag_cnt), 64'd0);
    do_req(32'h0000_2468, 0);
    wait_done(300);
    chk("t5_done_data", 64'(last_done_data), 64'h6869_6A6B);
    chk("t5_count", 64'(bus.fill_count), 64'd1);

    // back-to-back fills at different indices
    apply_reset();
    do_req(32'h0000_0040, 0);
    wait_done(300);
    do_req(32'h0001_0088, 0);
    wait_done(300);
    do_req(32'h0002_00FC, 0);
    wait_done(300);
    chk("t6_done_data", 64'(last_done_data), 64'hFCFD_FEFF);
    chk("t6_index", 64'(last_index), 64'h03);
    chk("t6_tag", 64'(last_tag), 64'h8);
    chk("t6_count", 64'(bus.fill_count), 64'd3);
    chk("t6_queues_empty", 64'(exp_q.size() + done_q.size() + addr_q.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
